// File: rtl/control_sequencer.sv
// Fetch/decode/execute control sequencer for a single-bus datapath.
// Moore outputs decoded from state and ir; pc_in in T1 additionally follows mem_ready.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | waiting for run
// T0      | PC -> MAR, PC+1 -> Z
// T1      | memory -> MDR, wait for mem_ready; Z -> PC on ready
// T2      | MDR -> IR
// T3      | decode; Rb -> Y for legal opcodes
// T4      | Rc -> ALU, result -> Z
// T5      | ZLow -> Ra (ALU ops) or ZLow -> LO (MUL/DIV)
// T6      | ZHigh -> HI (MUL/DIV only)
// HALTED  | halt opcode seen, terminal until reset
// ERROR   | illegal opcode seen, terminal until reset

module control_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        mem_ready,
    input  logic [31:0] ir,
    output logic [4:0]  bus_sel,
    output logic [15:0] reg_in,
    output logic        hi_in,
    output logic        lo_in,
    output logic        pc_in,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        ir_in,
    output logic        ry_in,
    output logic        rz_in,
    output logic        md_read,
    output logic [3:0]  alu_op,
    output logic        busy,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED, S_ERROR
    } state_t;

    localparam logic [4:0] BUS_PC    = 5'd20;
    localparam logic [4:0] BUS_MDR   = 5'd21;
    localparam logic [4:0] BUS_ZLOW  = 5'd19;
    localparam logic [4:0] BUS_ZHIGH = 5'd18;
    localparam logic [4:0] BUS_NONE  = 5'd31;
    localparam logic [3:0] ALU_INC   = 4'b1100;

    state_t state, state_nxt;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       legal, muldiv;
    logic       unused_ir_bits;

    assign opcode = ir[31:27];
    assign ra     = ir[26:23];
    assign rb     = ir[22:19];
    assign rc     = ir[18:15];
    assign legal  = (opcode <= 5'd9);
    assign muldiv = (opcode == 5'd8) || (opcode == 5'd9);
    assign unused_ir_bits = ^ir[14:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        bus_sel   = BUS_NONE;
        reg_in    = '0;
        hi_in     = 1'b0;
        lo_in     = 1'b0;
        pc_in     = 1'b0;
        mar_in    = 1'b0;
        mdr_in    = 1'b0;
        ir_in     = 1'b0;
        ry_in     = 1'b0;
        rz_in     = 1'b0;
        md_read   = 1'b0;
        alu_op    = 4'b0000;
        busy      = 1'b1;
        halted    = 1'b0;
        illegal   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (run) state_nxt = S_T0;
            end
            S_T0: begin
                bus_sel   = BUS_PC;
                mar_in    = 1'b1;
                alu_op    = ALU_INC;
                rz_in     = 1'b1;
                state_nxt = S_T1;
            end
            S_T1: begin
                bus_sel = BUS_ZLOW;
                md_read = 1'b1;
                mdr_in  = 1'b1;
                // PC loads only on the completing cycle so it advances once per fetch
                if (mem_ready) begin
                    pc_in     = 1'b1;
                    state_nxt = S_T2;
                end
            end
            S_T2: begin
                bus_sel   = BUS_MDR;
                ir_in     = 1'b1;
                state_nxt = S_T3;
            end
            S_T3: begin
                if (legal) begin
                    bus_sel   = {1'b0, rb};
                    ry_in     = 1'b1;
                    state_nxt = S_T4;
                end else if (opcode == 5'b11111) begin
                    state_nxt = S_HALTED;
                end else begin
                    state_nxt = S_ERROR;
                end
            end
            S_T4: begin
                bus_sel   = {1'b0, rc};
                alu_op    = opcode[3:0];
                rz_in     = 1'b1;
                state_nxt = S_T5;
            end
            S_T5: begin
                bus_sel = BUS_ZLOW;
                if (muldiv) begin
                    lo_in     = 1'b1;
                    state_nxt = S_T6;
                end else begin
                    reg_in    = 16'd1 << ra;
                    state_nxt = run ? S_T0 : S_IDLE;
                end
            end
            S_T6: begin
                bus_sel   = BUS_ZHIGH;
                hi_in     = 1'b1;
                state_nxt = run ? S_T0 : S_IDLE;
            end
            S_HALTED: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            S_ERROR: begin
                busy    = 1'b0;
                illegal = 1'b1;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle output vectors against hand-built tables.
`timescale 1ns/1ps
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = 32'h0;
    logic [4:0]  bus_sel;
    logic [15:0] reg_in;
    logic        hi_in, lo_in, pc_in, mar_in, mdr_in, ir_in, ry_in, rz_in, md_read;
    logic [3:0]  alu_op;
    logic        busy, halted, illegal;

    int n_cmp = 0;
    int n_err = 0;

    control_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
        .bus_sel(bus_sel), .reg_in(reg_in), .hi_in(hi_in), .lo_in(lo_in),
        .pc_in(pc_in), .mar_in(mar_in), .mdr_in(mdr_in), .ir_in(ir_in),
        .ry_in(ry_in), .rz_in(rz_in), .md_read(md_read), .alu_op(alu_op),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {bus_sel, reg_in, hi,lo,pc,mar,mdr,ir,ry,rz,md_read, alu_op, busy,halted,illegal}
    logic [36:0] obs;
    assign obs = {bus_sel, reg_in, hi_in, lo_in, pc_in, mar_in, mdr_in, ir_in,
                  ry_in, rz_in, md_read, alu_op, busy, halted, illegal};

    localparam logic [8:0] E_HI  = 9'h100, E_LO  = 9'h080, E_PC = 9'h040;
    localparam logic [8:0] E_MAR = 9'h020, E_MDR = 9'h010, E_IR = 9'h008;
    localparam logic [8:0] E_RY  = 9'h004, E_RZ  = 9'h002, E_MD = 9'h001;

    localparam logic [31:0] IR_AND  = 32'h1292_0000;
    localparam logic [31:0] IR_MUL  = 32'h4292_0000;
    localparam logic [31:0] IR_HALT = 32'hF800_0000;
    localparam logic [31:0] IR_BAD  = 32'h5000_0000;

    localparam logic [36:0] X_IDLE = {5'd31, 16'h0000, 9'h000, 4'h0, 3'b000};
    localparam logic [36:0] X_T0   = {5'd20, 16'h0000, E_MAR | E_RZ, 4'hC, 3'b100};
    localparam logic [36:0] X_T1W  = {5'd19, 16'h0000, E_MDR | E_MD, 4'h0, 3'b100};
    localparam logic [36:0] X_T1R  = {5'd19, 16'h0000, E_PC | E_MDR | E_MD, 4'h0, 3'b100};
    localparam logic [36:0] X_T2   = {5'd21, 16'h0000, E_IR, 4'h0, 3'b100};
    localparam logic [36:0] X_T3   = {5'd2,  16'h0000, E_RY, 4'h0, 3'b100};
    localparam logic [36:0] X_T3N  = {5'd31, 16'h0000, 9'h000, 4'h0, 3'b100};
    localparam logic [36:0] X_T4A  = {5'd4,  16'h0000, E_RZ, 4'h2, 3'b100};
    localparam logic [36:0] X_T4M  = {5'd4,  16'h0000, E_RZ, 4'h8, 3'b100};
    localparam logic [36:0] X_T5A  = {5'd19, 16'h0020, 9'h000, 4'h0, 3'b100};
    localparam logic [36:0] X_T5M  = {5'd19, 16'h0000, E_LO, 4'h0, 3'b100};
    localparam logic [36:0] X_T6   = {5'd18, 16'h0000, E_HI, 4'h0, 3'b100};
    localparam logic [36:0] X_HALT = {5'd31, 16'h0000, 9'h000, 4'h0, 3'b010};
    localparam logic [36:0] X_ERR  = {5'd31, 16'h0000, 9'h000, 4'h0, 3'b001};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL reset_hold: got %h expected %h", obs, X_IDLE);
        end
        reset = 1'b1;
        step();
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL reset_idle_no_run: got %h expected %h", obs, X_IDLE);
        end
    endtask

    task automatic test_and();
        logic [36:0] tbl [7];
        tbl = '{X_T0, X_T1R, X_T2, X_T3, X_T4A, X_T5A, X_T0};
        ir = IR_AND; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if (obs !== tbl[i]) begin
                n_err++;
                $display("FAIL and_cyc%0d: got %h expected %h", i, obs, tbl[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [36:0] tbl [5];
        tbl = '{X_T1R, X_T2, X_T3, X_T4A, X_T5A};
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs !== tbl[i]) begin
                n_err++;
                $display("FAIL b2b_cyc%0d: got %h expected %h", i, obs, tbl[i]);
            end
        end
        run = 1'b0;
        step();
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL b2b_exit_idle: got %h expected %h", obs, X_IDLE);
        end
    endtask

    task automatic test_mem_wait();
        ir = IR_AND; mem_ready = 1'b0; run = 1'b1;
        step();
        n_cmp++;
        if (obs !== X_T0) begin
            n_err++;
            $display("FAIL wait_t0: got %h expected %h", obs, X_T0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (obs !== X_T1W) begin
                n_err++;
                $display("FAIL wait_t1_cyc%0d: got %h expected %h", i, obs, X_T1W);
            end
        end
        step();
        mem_ready = 1'b1;
        #1;
        n_cmp++;
        if (obs !== X_T1R) begin
            n_err++;
            $display("FAIL wait_t1_ready: got %h expected %h", obs, X_T1R);
        end
        step();
        n_cmp++;
        if (obs !== X_T2) begin
            n_err++;
            $display("FAIL wait_t2: got %h expected %h", obs, X_T2);
        end
        run = 1'b0;
        repeat (4) step();
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL wait_exit_idle: got %h expected %h", obs, X_IDLE);
        end
    endtask

    task automatic test_mul();
        logic [36:0] tbl [6];
        tbl = '{X_T0, X_T1R, X_T2, X_T3, X_T4M, X_T5M};
        ir = IR_MUL; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            n_cmp++;
            if (obs !== tbl[i]) begin
                n_err++;
                $display("FAIL mul_cyc%0d: got %h expected %h", i, obs, tbl[i]);
            end
        end
        run = 1'b0;
        step();
        n_cmp++;
        if (obs !== X_T6) begin
            n_err++;
            $display("FAIL mul_t6: got %h expected %h", obs, X_T6);
        end
        step();
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL mul_exit_idle: got %h expected %h", obs, X_IDLE);
        end
    endtask

    task automatic test_terminal(input logic [31:0] op, input logic [36:0] final_x);
        logic [36:0] tbl [7];
        tbl = '{X_T0, X_T1R, X_T2, X_T3N, final_x, final_x, final_x};
        ir = op; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            n_cmp++;
            if (obs !== tbl[i]) begin
                n_err++;
                $display("FAIL term_%h_cyc%0d: got %h expected %h", op, i, obs, tbl[i]);
            end
        end
        reset = 1'b0;
        #2;
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL term_%h_reset_clear: got %h expected %h", op, obs, X_IDLE);
        end
        run = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_run_drop();
        logic [36:0] tbl [5];
        tbl = '{X_T0, X_T1R, X_T2, X_T3, X_T4A};
        ir = IR_AND; mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            n_cmp++;
            if (obs !== tbl[i]) begin
                n_err++;
                $display("FAIL drop_cyc%0d: got %h expected %h", i, obs, tbl[i]);
            end
        end
        run = 1'b0;
        step();
        n_cmp++;
        if (obs !== X_T5A) begin
            n_err++;
            $display("FAIL drop_t5_completes: got %h expected %h", obs, X_T5A);
        end
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (obs !== X_IDLE) begin
                n_err++;
                $display("FAIL drop_idle_cyc%0d: got %h expected %h", i, obs, X_IDLE);
            end
        end
    endtask

    task automatic test_reset_mid();
        ir = IR_AND; mem_ready = 1'b1; run = 1'b1;
        repeat (5) step();
        n_cmp++;
        if (obs !== X_T4A) begin
            n_err++;
            $display("FAIL rmid_t4: got %h expected %h", obs, X_T4A);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL rmid_async: got %h expected %h", obs, X_IDLE);
        end
        step();
        run = 1'b0;
        reset = 1'b1;
        step();
        n_cmp++;
        if (obs !== X_IDLE) begin
            n_err++;
            $display("FAIL rmid_release_idle: got %h expected %h", obs, X_IDLE);
        end
        run = 1'b1;
        step();
        n_cmp++;
        if (obs !== X_T0) begin
            n_err++;
            $display("FAIL rmid_restart_t0: got %h expected %h", obs, X_T0);
        end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_and();
        test_back_to_back();
        test_mem_wait();
        test_mul();
        test_terminal(IR_HALT, X_HALT);
        test_terminal(IR_BAD, X_ERR);
        test_run_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; reset=0 forces the reset state immediately.
REQ-003 run  in  1  level; 1 = keep fetching/executing, 0 = stop at the next instruction boundary.
REQ-004 mem_ready  in  1  memory read data valid on MdataIn this cycle.
REQ-005 ir  in  32  current IR contents, fed back from the datapath; opcode=ir[31:27], Ra=ir[26:23], Rb=ir[22:19], Rc=ir[18:15].
REQ-006 bus_sel  out  5  bus source code: 0-15=R0-R15, 16=HI, 17=LO, 18=ZHigh, 19=ZLow, 20=PC, 21=MDR, 31=none.
REQ-007 reg_in  out  16  one-hot register-file load enables, R0..R15.
REQ-008 hi_in, lo_in, pc_in, mar_in, mdr_in, ir_in, ry_in, rz_in  out  1 each  datapath load enables.
REQ-009 md_read  out  1  MDR mux selects memory data (1) or bus (0).
REQ-010 alu_op  out  4  ALU control code.
REQ-011 busy  out  1  1 in any state except IDLE, HALTED and ERROR.
REQ-012 halted, illegal  out  1 each  sticky status flags.

Function
REQ-013 States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED, ERROR; all outputs are Moore, decoded from the state and ir only.
REQ-014 Outputs not listed for a state are 0, and bus_sel=31.
REQ-015 IDLE: all enables 0; go to T0 when run=1.
REQ-016 T0: bus_sel=20, mar_in=1, alu_op=1100 (INC), rz_in=1; go to T1.
REQ-017 T1: bus_sel=19, md_read=1, mdr_in=1; pc_in=1 on the cycle mem_ready=1 only.
REQ-018 T1 holds while mem_ready=0; on mem_ready=1 go to T2; pc_in asserts exactly once per fetch.
REQ-019 T2: bus_sel=21, ir_in=1; go to T3.
REQ-020 T3 decode: opcode 00000-01001 = legal.
REQ-021 T3 on legal opcode: bus_sel=Rb, ry_in=1; go to T4.
REQ-022 T3 on opcode 11111: go to HALTED, no enables.
REQ-023 T3 on any other opcode: go to ERROR, no enables.
REQ-024 T4: bus_sel=Rc, alu_op=opcode[3:0], rz_in=1; go to T5.
REQ-025 Opcode map: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SHR, 5 SHL, 6 ROR, 7 ROL, 8 MUL, 9 DIV.
REQ-026 T5, opcodes 0-7: bus_sel=19, reg_in[Ra]=1, then exit per REQ-029.
REQ-027 T5, MUL/DIV: bus_sel=19, lo_in=1; go to T6.
REQ-028 T6: bus_sel=18, hi_in=1, then exit per REQ-029.
REQ-029 Exit: go to T0 if run=1, otherwise IDLE.
REQ-030 run is sampled only in IDLE and at the exit; dropping run mid-instruction still completes the instruction.
REQ-031 Latency at mem_ready=1: ALU op = 6 cycles T0-T5; MUL/DIV = 7 cycles; each wait cycle adds 1.
REQ-032 HALTED sets halted=1; ERROR sets illegal=1; both states are terminal until reset; run is ignored there.
REQ-033 reg_in is strictly one-hot or zero; at most one register-file enable per cycle.
REQ-034 Exactly one bus source per cycle, or none.

Reset
REQ-035 reset=0 asynchronously forces IDLE, all enables 0, alu_op=0000, bus_sel=31, busy=0, halted=0, illegal=0.
REQ-036 reset asserted mid-instruction aborts with no further enables; after release the block waits in IDLE for run.

Verification
REQ-037 Scenario, AND: run=1, mem_ready=1, ir=0x12920000 (AND R5,R2,R4).
  - T0-T5 in 6 cycles.
  - T3 bus_sel=2, ry_in=1.
  - T4 bus_sel=4, alu_op=0010, rz_in=1.
  - T5 bus_sel=19, reg_in=0x0020.
REQ-038 Scenario, memory wait: mem_ready held 0 for 3 cycles in T1 -> T1 lasts 4 cycles; pc_in=1 only in the final cycle.
REQ-039 Scenario, MUL: ir=0x42920000 -> T5 lo_in=1 with bus_sel=19; T6 hi_in=1 with bus_sel=18; 7 cycles total.
REQ-040 Scenario, halt and illegal:
  - ir=0xF8000000 -> HALTED after T3, halted=1, busy=0, no enables afterward.
  - opcode 01010 -> ERROR, illegal=1.
REQ-041 Scenario, run drop: run dropped during T4 -> T5 completes, then IDLE; busy falls the cycle after T5.
REQ-042 Scenario, reset mid-op: reset=0 asserted asynchronously during T4 -> outputs at reset values before the next clk edge; IDLE after release.
